// File: rtl/alu_cmd_sequencer.sv
// Byte-stream command sequencer for the shared 8-bit ALU: parses CC/DD commands, fires the ALU and
// returns the 16-bit result LSB first over valid/ready. Optional port via `ALU_CLK_GATE_EN.
module alu_cmd_sequencer #(
  parameter int unsigned          DATA_W     = 8,
  parameter int unsigned          RES_W      = 16,
  parameter int unsigned          TIMEOUT    = 15,
  parameter logic [DATA_W-1:0]    CMD_OPER   = 8'hCC,
  parameter logic [DATA_W-1:0]    CMD_NOOPER = 8'hDD
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [3:0]        o_alu_func,
  output logic              o_alu_en,
  input  logic [RES_W-1:0]  i_alu_result,
  input  logic              i_alu_valid,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
`ifdef ALU_CLK_GATE_EN
  output logic              o_alu_clk_en,
`endif
  output logic              o_busy,
  output logic              o_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StGetA, StGetB, StGetFn, StRun, StWait, StTxLo, StTxHi
  } state_e;

  state_e              r_state;
  logic [CntW-1:0]     r_cnt;
  logic [RES_W-1:0]    r_res;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [3:0]          r_alu_func;
  logic                r_alu_en;
  logic [DATA_W-1:0]   r_tx_data;
  logic                r_tx_valid;
  logic                r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_res      <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_func <= '0;
      r_alu_en   <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_alu_en <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_rx_valid) begin
            if (i_rx_data == CMD_OPER) begin
              r_state <= StGetA;
            end else if (i_rx_data == CMD_NOOPER) begin
              r_state <= StGetFn;
            end
          end
        end
        StGetA: begin
          if (i_rx_valid) begin
            r_alu_a <= i_rx_data;
            r_state <= StGetB;
          end
        end
        StGetB: begin
          if (i_rx_valid) begin
            r_alu_b <= i_rx_data;
            r_state <= StGetFn;
          end
        end
        StGetFn: begin
          if (i_rx_valid) begin
            r_alu_func <= i_rx_data[3:0];
            r_alu_en   <= 1'b1;
            r_state    <= StRun;
          end
        end
        StRun: begin
          r_cnt   <= '0;
          r_state <= StWait;
        end
        StWait: begin
          if (i_alu_valid) begin
            r_res      <= i_alu_result;
            r_tx_data  <= i_alu_result[DATA_W-1:0];
            r_tx_valid <= 1'b1;
            r_state    <= StTxLo;
          end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
            // ALU never answered: abort without sending anything
            r_err   <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StTxLo: begin
          if (i_tx_ready) begin
            r_tx_data <= r_res[RES_W-1:DATA_W];
            r_state   <= StTxHi;
          end
        end
        StTxHi: begin
          if (i_tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_func = r_alu_func;
  assign o_alu_en   = r_alu_en;
  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_err      = r_err;
  assign o_busy     = (r_state != StIdle);

`ifdef ALU_CLK_GATE_EN
  assign o_alu_clk_en = (r_state == StRun) || (r_state == StWait);
`endif

endmodule
